// File: rtl/iob_intr_pkt_encoder.sv
// Interrupt request queue feeding the fake-IOB NoC output: each queued request
// leaves as a 2-flit packet (header, then payload) over a val/rdy channel.
module iob_intr_pkt_encoder #(
    parameter int          X_TILES       = 2,
    parameter int          Y_TILES       = 2,
    parameter int          FIFO_DEPTH    = 4,
    parameter logic [7:0]  INTR_MSG_TYPE = 8'd32,
    parameter logic [3:0]  FBITS         = 4'b0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_val,
    output logic        req_rdy,
    input  logic [31:0] req_tileid,
    input  logic [63:0] req_data,
    output logic        noc_out_val,
    input  logic        noc_out_rdy,
    output logic [63:0] noc_out_data,
    output logic        err_badtile,
    output logic [15:0] pkt_count
);
    localparam int                NUM_TILES   = X_TILES * Y_TILES;
    localparam int                PTR_W       = $clog2(FIFO_DEPTH);
    localparam logic [31:0]       X_TILES_W   = 32'(X_TILES);
    localparam logic [31:0]       NUM_TILES_W = 32'(NUM_TILES);
    localparam logic [PTR_W:0]    DEPTH_W     = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [0:0]        ST_HDR      = 1'b0;
    localparam logic [0:0]        ST_PAY      = 1'b1;

    typedef struct packed {
        logic [7:0]  dx;
        logic [7:0]  dy;
        logic [63:0] pay;
    } entry_t;

    entry_t           mem_q [FIFO_DEPTH];
    entry_t           mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [0:0]       state_q, state_d;
    logic             err_q, err_d;
    logic [15:0]      pkt_count_q, pkt_count_d;

    logic             tile_ok, full, empty, push, pop;
    entry_t           new_entry, head;
    logic [63:0]      header;

    // Payload keeps data[63:16] and data[8:0]; bits 15:9 are forced to zero.
    assign tile_ok       = req_tileid < NUM_TILES_W;
    assign new_entry.dx  = 8'(req_tileid % X_TILES_W);
    assign new_entry.dy  = 8'(req_tileid / X_TILES_W);
    assign new_entry.pay = req_data & ~64'h0000_0000_0000_FE00;

    assign full    = (count_q == DEPTH_W);
    assign empty   = (count_q == '0);
    assign req_rdy = !full;
    assign push    = req_val && req_rdy && tile_ok;
    assign pop     = (state_q == ST_PAY) && noc_out_rdy;

    assign head   = mem_q[rd_ptr_q];
    assign header = {14'b0, head.dx, head.dy, FBITS, 8'd1, INTR_MSG_TYPE, 8'b0, 6'b0};

    assign noc_out_val  = (state_q == ST_PAY) || !empty;
    assign noc_out_data = !noc_out_val      ? 64'b0 :
                          (state_q == ST_HDR) ? header : head.pay;
    assign err_badtile  = err_q;
    assign pkt_count    = pkt_count_q;

    always_comb begin
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        state_d     = state_q;
        pkt_count_d = pkt_count_q;
        err_d       = req_val && req_rdy && !tile_ok;

        if (push) begin
            mem_d[wr_ptr_q] = new_entry;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d    = rd_ptr_q + 1'b1;
            pkt_count_d = pkt_count_q + 16'd1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        case (state_q)
            ST_HDR:  if (noc_out_val && noc_out_rdy) state_d = ST_PAY;
            ST_PAY:  if (noc_out_rdy) state_d = ST_HDR;
            default: state_d = ST_HDR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= ST_HDR;
            err_q       <= 1'b0;
            pkt_count_q <= 16'd0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            state_q     <= state_d;
            err_q       <= err_d;
            pkt_count_q <= pkt_count_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

// File: tb/tb_iob_intr_pkt_encoder.sv
// Bench for iob_intr_pkt_encoder: packet-queue model checked every cycle,
// plus directed scenarios pinned with hand-computed flit values.
module tb_iob_intr_pkt_encoder;
    localparam int XT = 2, YT = 2, NT = XT * YT, DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst, req_val, req_rdy, noc_out_val, noc_out_rdy, err_badtile;
    logic [31:0] req_tileid;
    logic [63:0] req_data, noc_out_data;
    logic [15:0] pkt_count;

    always #5 clk = ~clk;

    iob_intr_pkt_encoder #(
        .X_TILES(XT), .Y_TILES(YT), .FIFO_DEPTH(DEPTH),
        .INTR_MSG_TYPE(8'd32), .FBITS(4'b0000)
    ) dut (
        .clk(clk), .rst(rst),
        .req_val(req_val), .req_rdy(req_rdy),
        .req_tileid(req_tileid), .req_data(req_data),
        .noc_out_val(noc_out_val), .noc_out_rdy(noc_out_rdy),
        .noc_out_data(noc_out_data),
        .err_badtile(err_badtile), .pkt_count(pkt_count)
    );

    int vectors = 0, miscompares = 0;

    // Model: a queue of whole packets, a flag saying the head's header already left.
    logic [63:0] m_hdr[$], m_pay[$];
    bit          m_phase, m_err, m_live = 1'b0, m_rdy_now;
    logic [15:0] m_cnt;
    logic [63:0] flog[$];
    int          err_seen = 0;

    function automatic bit m_rdy();
        return m_hdr.size() < DEPTH;
    endfunction

    function automatic logic [63:0] hdr_of(int t);
        logic [63:0] x, y;
        x = 64'(t % XT);
        y = 64'(t / XT);
        return (x << 42) | (y << 34) | (64'd1 << 22) | (64'd32 << 14);
    endfunction

    function automatic logic [63:0] pay_of(logic [63:0] d);
        return d & ~64'h0000_0000_0000_FE00;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_hdr.delete();
            m_pay.delete();
            m_phase = 1'b0;
            m_cnt   = 16'd0;
            m_err   = 1'b0;
            m_live  = 1'b1;
        end else if (m_live) begin
            m_rdy_now = m_rdy();
            if (m_hdr.size() > 0 && noc_out_rdy) begin
                if (!m_phase) m_phase = 1'b1;
                else begin
                    void'(m_hdr.pop_front());
                    void'(m_pay.pop_front());
                    m_cnt   = m_cnt + 16'd1;
                    m_phase = 1'b0;
                end
            end
            m_err = 1'b0;
            if (req_val && m_rdy_now) begin
                if (req_tileid < NT) begin
                    m_hdr.push_back(hdr_of(int'(req_tileid)));
                    m_pay.push_back(pay_of(req_data));
                end else m_err = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            check("req_rdy", 64'(req_rdy), 64'(m_rdy()));
            check("noc_out_val", 64'(noc_out_val), 64'(m_hdr.size() > 0));
            check("noc_out_data", noc_out_data,
                  m_hdr.size() == 0 ? 64'd0 : (m_phase ? m_pay[0] : m_hdr[0]));
            check("err_badtile", 64'(err_badtile), 64'(m_err));
            check("pkt_count", 64'(pkt_count), 64'(m_cnt));
            if (noc_out_val && noc_out_rdy) flog.push_back(noc_out_data);
            if (err_badtile) err_seen++;
        end
    end

    task automatic send(int t, logic [63:0] d);
        bit acc = 1'b0;
        req_val    = 1'b1;
        req_tileid = 32'(t);
        req_data   = d;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            acc = m_rdy();
            @(posedge clk);
            #1;
        end
        req_val = 1'b0;
        if (!acc) check("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_flits(int n);
        for (int i = 0; i < 400 && flog.size() < n; i++) @(posedge clk);
        #1;
        check("flit_total", 64'(flog.size()), 64'(n));
    endtask

    int base, es;

    initial begin
        rst = 1'b1; req_val = 1'b0; noc_out_rdy = 1'b0;
        req_tileid = '0; req_data = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_rdy", 64'(req_rdy), 64'd1);
        check("reset_val", 64'(noc_out_val), 64'd0);
        check("reset_cnt", 64'(pkt_count), 64'd0);
        @(posedge clk); #1;

        // 1: single packet to tile 3
        noc_out_rdy = 1'b1;
        send(3, 64'hDEAD_BEEF_0000_01FF);
        wait_flits(2);
        repeat (2) @(posedge clk); #1;
        check("t1_hdr", flog[0], 64'h0000_0404_0048_0000);
        check("t1_pay", flog[1], 64'hDEAD_BEEF_0000_01FF);
        check("t1_cnt", 64'(pkt_count), 64'd1);

        // 2: bad tile dropped
        base = flog.size(); es = err_seen;
        send(7, 64'h1111_2222_3333_4444);
        repeat (4) @(posedge clk); #1;
        check("t2_noflit", 64'(flog.size()), 64'(base));
        check("t2_errpulse", 64'(err_seen - es), 64'd1);
        check("t2_cnt", 64'(pkt_count), 64'd1);

        // 3: fill queue while stalled
        noc_out_rdy = 1'b0;
        base = flog.size();
        for (int i = 0; i < 4; i++) send(i, {32'hA000_0000 + 32'(i), 32'h0000_FFFF});
        check("t3_full", 64'(req_rdy), 64'd0);
        req_val = 1'b1; req_tileid = 32'd1; req_data = 64'h5;
        repeat (3) @(posedge clk); #1;
        check("t3_held", 64'(req_rdy), 64'd0);
        req_val = 1'b0;
        noc_out_rdy = 1'b1;
        wait_flits(base + 8);
        check("t3_hdr0", flog[base], 64'h0000_0000_0048_0000);
        check("t3_pay0", flog[base + 1], 64'hA000_0000_0000_01FF);
        check("t3_pay3", flog[base + 7], 64'hA000_0003_0000_01FF);
        repeat (2) @(posedge clk); #1;
        check("t3_cnt", 64'(pkt_count), 64'd5);

        // 4: ready toggling every cycle
        base = flog.size();
        fork
            for (int i = 0; i < 30; i++) begin
                @(posedge clk); #1;
                noc_out_rdy = ~noc_out_rdy;
            end
            begin
                send(0, 64'h1234_5678_9ABC_FFFF);
                send(1, 64'h0BAD_F00D_0000_0100);
                send(2, 64'h0);
            end
        join
        noc_out_rdy = 1'b1;
        wait_flits(base + 6);
        check("t4_pay0", flog[base + 1], 64'h1234_5678_9ABC_01FF);
        check("t4_hdr1", flog[base + 2], 64'h0000_0400_0048_0000);
        check("t4_pay1", flog[base + 3], 64'h0BAD_F00D_0000_0100);
        repeat (2) @(posedge clk); #1;
        check("t4_cnt", 64'(pkt_count), 64'd8);

        // 5: reset while in payload phase with two queued
        noc_out_rdy = 1'b0;
        send(2, 64'h5555_AAAA_0000_0F0F);
        send(3, 64'h6);
        noc_out_rdy = 1'b1;
        @(posedge clk); #1;
        noc_out_rdy = 1'b0;
        check("t5_pay_val", 64'(noc_out_val), 64'd1);
        check("t5_pay_data", noc_out_data, 64'h5555_AAAA_0000_010F);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("t5_val", 64'(noc_out_val), 64'd0);
        check("t5_cnt", 64'(pkt_count), 64'd0);
        check("t5_rdy", 64'(req_rdy), 64'd1);
        base = flog.size();
        noc_out_rdy = 1'b1;
        repeat (3) @(posedge clk); #1;
        check("t5_noflit", 64'(flog.size()), 64'(base));

        // 6: 20 back-to-back packets
        base = flog.size();
        for (int i = 0; i < 20; i++) send(i % 4, {32'hC000_0000 + 32'(i), 32'(i)});
        wait_flits(base + 40);
        repeat (2) @(posedge clk); #1;
        check("t6_cnt", 64'(pkt_count), 64'd20);
        check("t6_hdr19", flog[base + 38], 64'h0000_0404_0048_0000);
        check("t6_pay19", flog[base + 39], 64'hC000_0013_0000_0013);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
